// File: rtl/sysbus_pkg.sv
// System-bus definitions shared by the memory responder and the initiators that talk to it.
// Tag layout: bit 12 op, bits 11:8 target type, bits 7:0 transaction id.
package sysbus_pkg;

  localparam logic       OP_READ      = 1'b1;
  localparam logic       OP_WRITE     = 1'b0;
  localparam logic [3:0] TYPE_MEMORY  = 4'h1;
  localparam int         TAG_WIDTH    = 13;
  localparam int         LINE_BEATS   = 8;
  localparam int         TAG_OP_BIT   = 12;
  localparam int         TAG_TYPE_MSB = 11;
  localparam int         TAG_TYPE_LSB = 8;

  typedef enum logic [1:0] {
    IDLE,
    WDATA,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with one-cycle registered read; write has priority over read.
// rdata only changes on an enabled read, so it holds a beat while the consumer stalls.
module mem_array #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts line-sized reads and writes from one initiator and streams
// each read line back as eight beats after a fixed access latency.
module mem_responder
  import sysbus_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int TAG_WIDTH   = sysbus_pkg::TAG_WIDTH,
  parameter int DEPTH_LINES = 64,
  parameter int LATENCY     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reqcyc,
  input  logic [DATA_WIDTH-1:0] req,
  input  logic [TAG_WIDTH-1:0]  reqtag,
  output logic                  reqack,
  output logic                  respcyc,
  output logic [DATA_WIDTH-1:0] resp,
  output logic [TAG_WIDTH-1:0]  resptag,
  input  logic                  respack,
  output logic                  err
);

  localparam int         LINE_W    = $clog2(DEPTH_LINES);
  localparam int         ADDR_W    = LINE_W + 3;
  localparam logic [2:0] LAST_BEAT = 3'(LINE_BEATS - 1);
  localparam logic [3:0] WAIT_LOAD = 4'(LATENCY);

  state_t                state_reg, state_next;
  logic [3:0]            wait_cnt_reg, wait_cnt_next;
  logic [2:0]            beat_reg, beat_next;
  logic [LINE_W-1:0]     line_reg, line_next;
  logic [TAG_WIDTH-1:0]  tag_reg, tag_next;
  logic                  reqack_reg, reqack_next;
  logic                  respcyc_reg, respcyc_next;
  logic                  err_reg, err_next;

  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_W-1:0]     ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic [2:0]            beat_inc;
  logic                  req_is_mem;
  logic                  req_is_read;

  assign beat_inc    = beat_reg + 3'd1;
  assign req_is_mem  = (reqtag[TAG_TYPE_MSB:TAG_TYPE_LSB] == TYPE_MEMORY);
  assign req_is_read = (reqtag[TAG_OP_BIT] == OP_READ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      beat_reg     <= '0;
      line_reg     <= '0;
      tag_reg      <= '0;
      reqack_reg   <= 1'b0;
      respcyc_reg  <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      beat_reg     <= beat_next;
      line_reg     <= line_next;
      tag_reg      <= tag_next;
      reqack_reg   <= reqack_next;
      respcyc_reg  <= respcyc_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    beat_next     = beat_reg;
    line_next     = line_reg;
    tag_next      = tag_reg;
    reqack_next   = 1'b0;
    respcyc_next  = 1'b0;
    err_next      = err_reg;
    ram_en        = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = {line_reg, beat_reg};

    case (state_reg)
      IDLE: begin
        if (reqcyc) begin
          reqack_next = 1'b1;
          tag_next    = reqtag;
          line_next   = req[LINE_W+5:6];
          beat_next   = '0;
          if (!req_is_mem) begin
            err_next = 1'b1;
          end else if (req_is_read) begin
            state_next    = WAIT;
            wait_cnt_next = WAIT_LOAD;
          end else begin
            state_next = WDATA;
          end
        end
      end

      WDATA: begin
        if (reqcyc) begin
          ram_we      = 1'b1;
          reqack_next = 1'b1;
          beat_next   = beat_inc;
          if (beat_reg == LAST_BEAT) begin
            state_next = IDLE;
          end
        end
      end

      WAIT: begin
        // Word 0 is fetched on the edge that enters RESP so it is on resp with respcyc.
        if (wait_cnt_reg <= 4'd1) begin
          wait_cnt_next = '0;
          state_next    = RESP;
          respcyc_next  = 1'b1;
          beat_next     = '0;
          ram_en        = 1'b1;
          ram_addr      = {line_reg, 3'd0};
        end else begin
          wait_cnt_next = wait_cnt_reg - 4'd1;
        end
      end

      RESP: begin
        respcyc_next = 1'b1;
        if (respack) begin
          if (beat_reg == LAST_BEAT) begin
            state_next   = IDLE;
            respcyc_next = 1'b0;
            beat_next    = '0;
          end else begin
            beat_next = beat_inc;
            ram_en    = 1'b1;
            ram_addr  = {line_reg, beat_inc};
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  mem_array #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH_LINES * LINE_BEATS)
  ) u_mem (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (req),
    .rdata (ram_rdata)
  );

  assign reqack  = reqack_reg;
  assign respcyc = respcyc_reg;
  assign resp    = respcyc_reg ? ram_rdata : '0;
  assign resptag = tag_reg;
  assign err     = err_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: read beats are scoreboarded against a line model,
// handshake timing and error/reset behaviour are checked per scenario.
module tb_mem_responder;
  import sysbus_pkg::*;

  typedef struct packed {
    logic [63:0] data;
    logic [12:0] tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reqcyc = 1'b0;
  logic [63:0] req = '0;
  logic [12:0] reqtag = '0;
  logic        respack = 1'b0;
  logic        reqack;
  logic        respcyc;
  logic [63:0] resp;
  logic [12:0] resptag;
  logic        err;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [63:0] model [64][8];
  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          beats_seen = 0;
  logic        prev_pending = 1'b0;
  logic [63:0] prev_resp = '0;
  logic [12:0] prev_tag = '0;

  mem_responder #(
    .DATA_WIDTH  (64),
    .TAG_WIDTH   (13),
    .DEPTH_LINES (64),
    .LATENCY     (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .reqcyc  (reqcyc),
    .req     (req),
    .reqtag  (reqtag),
    .reqack  (reqack),
    .respcyc (respcyc),
    .resp    (resp),
    .resptag (resptag),
    .respack (respack),
    .err     (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Scoreboard: consume a beat whenever respcyc and respack are both high.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (prev_pending) begin
        checks++;
        if (respcyc !== 1'b1 || resp !== prev_resp || resptag !== prev_tag) begin
          errors++;
          $display("FAIL beat_hold: respcyc=%b resp=%h resptag=%h, required respcyc=1 resp=%h resptag=%h",
                   respcyc, resp, resptag, prev_resp, prev_tag);
        end
      end
      if (respcyc === 1'b1 && respack === 1'b1) begin
        checks++;
        beats_seen++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: resp=%h resptag=%h, required no beat", resp, resptag);
        end else begin
          mon_e = exp_q.pop_front();
          if (resp !== mon_e.data || resptag !== mon_e.tag) begin
            errors++;
            $display("FAIL beat_data: resp=%h resptag=%h, required resp=%h resptag=%h",
                     resp, resptag, mon_e.data, mon_e.tag);
          end else begin
            $display("beat ok: resp=%h resptag=%h", resp, resptag);
          end
        end
      end
      prev_pending = (respcyc === 1'b1) && (respack !== 1'b1);
      prev_resp    = resp;
      prev_tag     = resptag;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [63:0] addr, input logic [12:0] tag);
    @(posedge clk); #1;
    reqcyc = 1'b1; req = addr; reqtag = tag;
    @(posedge clk); #1;
    reqcyc = 1'b0; req = '0;
  endtask

  task automatic push_line(input logic [63:0] addr, input logic [7:0] id);
    int ln;
    ln = int'(addr[11:6]);
    for (int i = 0; i < 8; i++) exp_q.push_back(exp_t'{model[ln][i], {OP_READ, TYPE_MEMORY, id}});
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [7:0][63:0] w, input bit gappy,
                          output int acks);
    int ln;
    ln = int'(addr[11:6]);
    acks = 0;
    @(posedge clk); #1;
    reqcyc = 1'b1; req = addr; reqtag = {OP_WRITE, TYPE_MEMORY, 8'h00};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); if (reqack === 1'b1) acks++;
      @(posedge clk); #1;
      if (gappy && (i % 2 == 1)) begin
        reqcyc = 1'b0; req = '1;
        @(negedge clk); if (reqack === 1'b1) acks++;
        @(posedge clk); #1;
      end
      reqcyc = 1'b1; req = w[i]; model[ln][i] = w[i];
    end
    @(negedge clk); if (reqack === 1'b1) acks++;
    @(posedge clk); #1;
    reqcyc = 1'b0; req = '0;
    repeat (3) begin
      @(negedge clk); if (reqack === 1'b1) acks++;
      @(posedge clk); #1;
    end
    $display("write addr=%h acks=%0d", addr, acks);
  endtask

  task automatic run_read(input logic [63:0] addr, input logic [7:0] id, input bit toggle,
                          output int lat, output int span, output int nbeats, output logic after);
    int start, ack_cyc, first, last;
    start = beats_seen; ack_cyc = -1; first = -1; last = -1;
    push_line(addr, id);
    respack = 1'b1;
    issue(addr, {OP_READ, TYPE_MEMORY, id});
    for (int c = 0; c < 80 && (beats_seen - start) < 8; c++) begin
      respack = toggle ? (c % 3 == 0) : 1'b1;
      @(negedge clk);
      if (reqack === 1'b1 && ack_cyc < 0) ack_cyc = cycle;
      if (respcyc === 1'b1) begin
        if (first < 0) first = cycle;
        last = cycle;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    after  = respcyc;
    nbeats = beats_seen - start;
    lat    = (ack_cyc < 0 || first < 0) ? -1 : first - ack_cyc;
    span   = (first < 0) ? -1 : last - first;
    $display("read addr=%h id=%h beats=%0d lat=%0d span=%0d", addr, id, nbeats, lat, span);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (reqack !== 1'b0) begin errors++; $display("FAIL reset_reqack: got %b, required 0", reqack); end
    checks++; if (respcyc !== 1'b0) begin errors++; $display("FAIL reset_respcyc: got %b, required 0", respcyc); end
    checks++; if (resp !== 64'h0) begin errors++; $display("FAIL reset_resp: got %h, required 0", resp); end
    checks++; if (resptag !== 13'h0) begin errors++; $display("FAIL reset_resptag: got %h, required 0", resptag); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", err); end
    @(posedge clk); #1;
    reset = 1'b0;
    $display("reset released");
  endtask

  task automatic test_write_read();
    logic [7:0][63:0] w;
    int acks, lat, span, nb;
    logic after;
    for (int i = 0; i < 8; i++) w[i] = 64'h11 * 64'(i + 1);
    do_write(64'h1000, w, 1'b0, acks);
    checks++; if (acks !== 9) begin errors++; $display("FAIL write_acks: got %0d, required 9", acks); end
    run_read(64'h1000, 8'h5A, 1'b0, lat, span, nb, after);
    checks++; if (nb !== 8) begin errors++; $display("FAIL read_beats: got %0d, required 8", nb); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL read_latency: got %0d, required 4", lat); end
    checks++; if (span !== 7) begin errors++; $display("FAIL read_no_bubbles: span %0d, required 7", span); end
    checks++; if (after !== 1'b0) begin errors++; $display("FAIL read_end_respcyc: got %b, required 0", after); end
  endtask

  task automatic test_offset_and_wrap();
    int lat, span, nb;
    logic after;
    run_read(64'h1038, 8'h10, 1'b0, lat, span, nb, after);
    checks++; if (nb !== 8) begin errors++; $display("FAIL offset_beats: got %0d, required 8", nb); end
    run_read(64'h0000, 8'h11, 1'b0, lat, span, nb, after);
    checks++; if (nb !== 8) begin errors++; $display("FAIL wrap_beats: got %0d, required 8", nb); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL wrap_latency: got %0d, required 4", lat); end
  endtask

  task automatic test_gaps_toggle();
    logic [7:0][63:0] w;
    int acks, lat, span, nb;
    logic after;
    for (int i = 0; i < 8; i++) w[i] = {32'hC0DE0000 | 32'(i), $urandom()};
    do_write(64'h2040, w, 1'b1, acks);
    checks++; if (acks !== 9) begin errors++; $display("FAIL gap_write_acks: got %0d, required 9", acks); end
    run_read(64'h2040, 8'h21, 1'b1, lat, span, nb, after);
    checks++; if (nb !== 8) begin errors++; $display("FAIL toggle_beats: got %0d, required 8", nb); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL toggle_latency: got %0d, required 4", lat); end
    checks++; if (span <= 7) begin errors++; $display("FAIL toggle_stall: span %0d, required above 7", span); end
    checks++; if (after !== 1'b0) begin errors++; $display("FAIL toggle_end_respcyc: got %b, required 0", after); end
  endtask

  task automatic test_back_to_back();
    int start, acks, ack2, last_a;
    bit held, first_seen;
    start = beats_seen; acks = 0; ack2 = -1; last_a = -1; held = 0; first_seen = 0;
    push_line(64'h1000, 8'h01);
    push_line(64'h2040, 8'h02);
    respack = 1'b1;
    issue(64'h1000, {OP_READ, TYPE_MEMORY, 8'h01});
    for (int c = 0; c < 120 && (beats_seen - start) < 16; c++) begin
      @(negedge clk);
      if (reqack === 1'b1) begin
        acks++;
        if (held && ack2 < 0) ack2 = cycle;
      end
      if (respcyc === 1'b1 && ack2 < 0) begin
        last_a = cycle;
        first_seen = 1;
      end
      @(posedge clk); #1;
      if (first_seen && !held) begin
        held = 1; reqcyc = 1'b1; req = 64'h2040; reqtag = {OP_READ, TYPE_MEMORY, 8'h02};
      end else if (ack2 >= 0) begin
        reqcyc = 1'b0; req = '0;
      end
    end
    reqcyc = 1'b0;
    $display("back_to_back acks=%0d ack2=%0d last_a=%0d", acks, ack2, last_a);
    checks++; if (beats_seen - start !== 16) begin errors++; $display("FAIL b2b_beats: got %0d, required 16", beats_seen - start); end
    checks++; if (acks !== 2) begin errors++; $display("FAIL b2b_acks: got %0d, required 2", acks); end
    checks++; if (ack2 !== last_a + 2) begin errors++; $display("FAIL b2b_ack_cycle: got %0d, required %0d", ack2, last_a + 2); end
  endtask

  task automatic test_bad_type();
    int acks, lat, span, nb;
    logic seen, after;
    acks = 0; seen = 1'b0;
    issue(64'h1000, {OP_READ, 4'h2, 8'h33});
    repeat (12) begin
      @(negedge clk);
      if (reqack === 1'b1) acks++;
      if (respcyc === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    $display("bad_type acks=%0d err=%b respcyc_seen=%b", acks, err, seen);
    checks++; if (acks !== 1) begin errors++; $display("FAIL bad_type_acks: got %0d, required 1", acks); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_type_err: got %b, required 1", err); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL bad_type_respcyc: got %b, required 0", seen); end
    run_read(64'h2040, 8'h44, 1'b0, lat, span, nb, after);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b, required 1", err); end
    checks++; if (nb !== 8) begin errors++; $display("FAIL after_err_beats: got %0d, required 8", nb); end
  endtask

  task automatic test_reset_mid_read();
    int start, lat, span, nb;
    logic seen, after;
    start = beats_seen;
    push_line(64'h1000, 8'h77);
    respack = 1'b1;
    issue(64'h1000, {OP_READ, TYPE_MEMORY, 8'h77});
    for (int c = 0; c < 40 && (beats_seen - start) < 3; c++) begin
      @(posedge clk); #1;
    end
    checks++; if (respcyc !== 1'b1) begin errors++; $display("FAIL mid_read_active: respcyc %b, required 1", respcyc); end
    #1 reset = 1'b1;
    #1;
    checks++; if (respcyc !== 1'b0) begin errors++; $display("FAIL abort_respcyc: got %b, required 0", respcyc); end
    checks++; if (resp !== 64'h0) begin errors++; $display("FAIL abort_resp: got %h, required 0", resp); end
    checks++; if (resptag !== 13'h0) begin errors++; $display("FAIL abort_resptag: got %h, required 0", resptag); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL abort_err: got %b, required 0", err); end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk); if (respcyc === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    $display("reset mid-read: quiet after release respcyc_seen=%b", seen);
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_quiet: respcyc seen %b, required 0", seen); end
    run_read(64'h1000, 8'h78, 1'b0, lat, span, nb, after);
    checks++; if (nb !== 8) begin errors++; $display("FAIL reread_beats: got %0d, required 8", nb); end
  endtask

  task automatic test_reset_mid_write();
    logic [7:0][63:0] w;
    int acks, lat, span, nb;
    logic after;
    for (int i = 0; i < 8; i++) w[i] = 64'hA000_0000_0000_0000 | 64'(i);
    do_write(64'h3080, w, 1'b0, acks);
    @(posedge clk); #1;
    reqcyc = 1'b1; req = 64'h0080; reqtag = {OP_WRITE, TYPE_MEMORY, 8'h09};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      req = 64'hB000_0000_0000_0000 | 64'(i);
      model[2][i] = req;
    end
    @(posedge clk); #1;
    reqcyc = 1'b0; req = '0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    $display("reset mid-write after 3 words");
    run_read(64'h3080, 8'h0A, 1'b0, lat, span, nb, after);
    checks++; if (nb !== 8) begin errors++; $display("FAIL partial_write_beats: got %0d, required 8", nb); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL partial_write_latency: got %0d, required 4", lat); end
  endtask

  initial begin : main
    test_reset();
    test_write_read();
    test_offset_and_wrap();
    test_gaps_toggle();
    test_back_to_back();
    test_bad_type();
    test_reset_mid_read();
    test_reset_mid_write();
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d beats outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
